// File: rtl/digit_mul_pkg.sv
// digit_mul_pkg: shared types and helpers for the digit-serial multiplier.
// The STALL state is only reachable when DIGIT_MUL_OBUF_EN is defined.
package digit_mul_pkg;

   // IDLE/BUSY are common; DONE is the hold state without the output
   // register, STALL waits for the output register to free up.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      STALL = 2'd3
   } state_t;

   // Number of D-bit digits needed to cover a LOGQ-bit operand.
   function automatic int dmul_ndig(input int logq, input int d);
      return (logq + d - 1) / d;
   endfunction

   // Cycles from operand acceptance to out_valid; lets the wrapper in
   // front of the reduction stage size its side-band delay lines.
   function automatic int dmul_lat(input int logq, input int d);
      return dmul_ndig(logq, d);
   endfunction

endpackage

// File: rtl/digit_mul_if.sv
// digit_mul_if: operand and result handshake bundle for digit_mul.
// Both channels use valid/ready: a transfer happens on a rising clock
// edge where valid and ready are both high; the producer holds its payload
// while valid is high and ready is low, and ready never depends on the
// payload.
interface digit_mul_if #(
   parameter int LOGQ  = 60,
   parameter int LOGQH = 43
);
   logic                in_valid;
   logic                in_ready;
   logic [LOGQ-1:0]     A;
   logic [LOGQ-1:0]     B;
   logic [LOGQH-1:0]    qH;
   logic                out_valid;
   logic                out_ready;
   logic [2*LOGQ-1:0]   C;
   logic [LOGQH-1:0]    qH_o;

   modport master (
      output in_valid, A, B, qH, out_ready,
      input  in_ready, out_valid, C, qH_o
   );

   modport slave (
      input  in_valid, A, B, qH, out_ready,
      output in_ready, out_valid, C, qH_o
   );
endinterface

// File: rtl/digit_mul_obuf.sv
// dmul_obuf: one-entry output register for digit_mul, used only when
// DIGIT_MUL_OBUF_EN is defined. The core loads it only while free is high.
module dmul_obuf #(
   parameter int CW = 120,
   parameter int QW = 43
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] c_in,
   input  logic [QW-1:0] qh_in,
   input  logic          ready,
   output logic          valid,
   output logic [CW-1:0] c,
   output logic [QW-1:0] qh,
   output logic          free
);

   // Free when empty, or when the held result is drained on this edge.
   assign free = !valid || ready;

   // Output register: load beats drain, payload only changes on load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         c     <= '0;
         qh    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         c     <= c_in;
         qh    <= qh_in;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/digit_mul.sv
// digit_mul: digit-serial unsigned multiplier C = A*B feeding the word-level
// Montgomery reduction stage; qH rides along so C and qH arrive together.
// One LOGQ x D multiplier is reused for NDIG cycles.
// Optional feature macro: DIGIT_MUL_OBUF_EN adds a decoupled output register
// so the next operation can start while a result waits for out_ready.
module digit_mul
   import digit_mul_pkg::*;
#(
   parameter int LOGQ  = 60,
   parameter int LOGQH = 43,
   parameter int D     = 16
) (
   input  logic          clk,
   input  logic          rst,
   digit_mul_if.slave    bus,
   output state_t        dbg_state
);

   localparam int NDIG = dmul_ndig(LOGQ, D);
   localparam int BW   = NDIG * D;
   localparam int CW   = 2 * LOGQ;
   localparam int PW   = LOGQ + D;
   localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t            state;
   logic [LOGQ-1:0]   a_r;
   logic [BW-1:0]     b_r;
   logic [LOGQH-1:0]  qh_r;
   logic [CW-1:0]     acc;
   logic [CNTW-1:0]   cnt;

   logic [D-1:0]      digit;
   logic [PW-1:0]     pp;
   logic [CW-1:0]     sum;
   logic              last;

   // Partial product of the current B digit, aligned and added to acc.
   // The exact product fits 2*LOGQ bits, so nothing is lost by the width.
   always_comb begin
      digit = b_r[cnt*D +: D];
      pp    = PW'(a_r) * PW'(digit);
      sum   = acc + (CW'(pp) << (cnt * D));
      last  = (cnt == CNTW'(NDIG - 1));
   end

   assign bus.in_ready = (state == IDLE);
   assign dbg_state    = state;

`ifdef DIGIT_MUL_OBUF_EN
   logic            ob_free;
   logic            ob_load;
   logic [CW-1:0]   ob_c;
   logic            ob_valid;
   logic [CW-1:0]   ob_c_q;
   logic [LOGQH-1:0] ob_qh_q;

   // Load straight from the adder on the last digit, or from the held
   // accumulator when leaving STALL.
   always_comb begin
      ob_load = ob_free && ((state == BUSY && last) || state == STALL);
      ob_c    = (state == BUSY) ? sum : acc;
   end

   dmul_obuf #(.CW(CW), .QW(LOGQH)) u_obuf (
      .clk   (clk),
      .rst   (rst),
      .load  (ob_load),
      .c_in  (ob_c),
      .qh_in (qh_r),
      .ready (bus.out_ready),
      .valid (ob_valid),
      .c     (ob_c_q),
      .qh    (ob_qh_q),
      .free  (ob_free)
   );

   assign bus.out_valid = ob_valid;
   assign bus.C         = ob_c_q;
   assign bus.qH_o      = ob_qh_q;

   // Core FSM: capture operands, accumulate NDIG digits, hand off the sum.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         qh_r  <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r   <= bus.A;
                  b_r   <= BW'(bus.B);
                  qh_r  <= bus.qH;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= sum;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= ob_free ? IDLE : STALL;
               end
            end
            STALL: begin
               if (ob_free) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic              ov_r;
   logic [CW-1:0]     c_r;
   logic [LOGQH-1:0]  qh_o_r;

   assign bus.out_valid = ov_r;
   assign bus.C         = c_r;
   assign bus.qH_o      = qh_o_r;

   // Core FSM: capture operands, accumulate NDIG digits, hold result in DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         qh_r   <= '0;
         acc    <= '0;
         cnt    <= '0;
         ov_r   <= 1'b0;
         c_r    <= '0;
         qh_o_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r   <= bus.A;
                  b_r   <= BW'(bus.B);
                  qh_r  <= bus.qH;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= sum;
               cnt <= cnt + 1'b1;
               if (last) begin
                  c_r    <= sum;
                  qh_o_r <= qh_r;
                  ov_r   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  ov_r  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_digit_mul.sv
// tb_digit_mul: directed and streamed checks for digit_mul (LOGQ=60, D=16).
// Builds with or without DIGIT_MUL_OBUF_EN; expectations follow the macro.
module tb_digit_mul;
   import digit_mul_pkg::*;

   localparam int LOGQ  = 60;
   localparam int LOGQH = 43;
   localparam int D     = 16;
   localparam int NDIG  = 4;
   localparam int CW    = 2 * LOGQ;
`ifdef DIGIT_MUL_OBUF_EN
   localparam int SPACING = 5;
`else
   localparam int SPACING = 6;
`endif

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst = 1'b0;
   state_t dbg_state;
   int     cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   digit_mul_if #(.LOGQ(LOGQ), .LOGQH(LOGQH)) bus ();

   digit_mul #(.LOGQ(LOGQ), .LOGQH(LOGQH), .D(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [CW+LOGQH-1:0] exp_q[$];
   int                  lat_q[$];
   int                  n_checks = 0;
   int                  n_fail   = 0;
   int                  rdy_mode = 0;   // 0 low, 1 high, 2 random 70%
   int                  junk_cyc;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // out_ready driver: updates 2 time units after each rising edge.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 99) < 70);
         endcase
      end
   end

   task automatic send(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                       input logic [LOGQH-1:0] qh, input logic [CW-1:0] exp_c,
                       input bit push, output int acc_cyc);
      bit ok;
      ok = 1'b0;
      acc_cyc = -1;
      bus.in_valid = 1'b1;
      bus.A  = a;
      bus.B  = b;
      bus.qH = qh;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      bus.in_valid = 1'b0;
      // Scramble the payload: the block must not rely on it after accept.
      bus.A  = LOGQ'({$urandom(), $urandom()});
      bus.B  = LOGQ'({$urandom(), $urandom()});
      bus.qH = LOGQH'({$urandom(), $urandom()});
      if (ok) begin
         acc_cyc = cyc;
         if (push) begin
            exp_q.push_back({exp_c, qh});
            lat_q.push_back(cyc);
         end
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
      end
   endtask

   task automatic wait_drain(input int budget);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
         lat_q.delete();
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic                prev_ov;
      logic [CW+LOGQH-1:0] e;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_ov = 1'b0;
         end else begin
            if (bus.out_valid && !prev_ov && lat_q.size() > 0)
               check("latency", 192'(cyc - lat_q[0]), 192'(NDIG));
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got C=%h, required no result", bus.C);
               end else begin
                  e = exp_q.pop_front();
                  void'(lat_q.pop_front());
                  check("C", bus.C, e[CW+LOGQH-1:LOGQH]);
                  check("qH_o", bus.qH_o, e[LOGQH-1:0]);
               end
            end
            prev_ov = bus.out_valid;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #3000000;
      n_fail++;
      $display("FAIL watchdog: time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int               t1;
      int               t_prev;
      bit               got;
      logic [LOGQ-1:0]  a;
      logic [LOGQ-1:0]  b;
      logic [LOGQH-1:0] q;
      logic [CW-1:0]    g;

      // Reset held two cycles with in_valid asserted.
      bus.in_valid = 1'b1;
      bus.A  = 60'h1;
      bus.B  = 60'h2;
      bus.qH = 43'h3;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_C", bus.C, 0);
      check("rst_qH_o", bus.qH_o, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_state", dbg_state, IDLE);
      @(posedge clk);
      #1;

      // Directed vectors, out_ready high.
      rdy_mode = 1;
      send(60'hFFFFFFFFFFFFFFF, 60'hFFFFFFFFFFFFFFF, 43'h5A5A5A5A5A5,
           120'hFFFFFFFFFFFFFFE000000000000001, 1, junk_cyc);
      wait_drain(50);
      send(60'h123456789, 60'h0, 43'h11, 120'h0, 1, junk_cyc);
      wait_drain(50);
      send(60'h1, 60'h0FFFF0000, 43'h22, 120'hFFFF0000, 1, junk_cyc);
      wait_drain(50);
      send(60'h10000, 60'hFFFF, 43'h33, 120'hFFFF0000, 1, junk_cyc);
      wait_drain(50);
      send(60'hFFFF, 60'h10001, 43'h44, 120'hFFFFFFFF, 1, junk_cyc);
      wait_drain(50);
      send(60'h800000000000000, 60'h800000000000000, 43'h7FFFFFFFFFF,
           120'h400000000000000000000000000000, 1, junk_cyc);
      wait_drain(50);

      // Backpressure: result held for 10 cycles with out_ready low.
      rdy_mode = 0;
      send(60'hABCDE, 60'h1000, 43'h7FF, 120'hABCDE000, 1, junk_cyc);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("bp_out_valid", got, 1);
`ifdef DIGIT_MUL_OBUF_EN
      fork
         send(60'h3, 60'h7, 43'h1, 120'h15, 1, junk_cyc);
      join_none
`endif
      for (int i = 0; i < 10; i++) begin
         check("bp_C_stable", bus.C, 120'hABCDE000);
         check("bp_qH_o_stable", bus.qH_o, 43'h7FF);
         check("bp_valid_held", bus.out_valid, 1);
`ifndef DIGIT_MUL_OBUF_EN
         check("bp_in_ready", bus.in_ready, 0);
`endif
         @(negedge clk);
      end
`ifdef DIGIT_MUL_OBUF_EN
      check("bp_stall", dbg_state, STALL);
`endif
      rdy_mode = 1;
      wait_drain(50);

      // Reset while the accumulator is at cnt==2.
      send(60'h7, 60'h9, 43'h2, 120'h3F, 0, junk_cyc);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("mid_state_busy", dbg_state, BUSY);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_state_idle", dbg_state, IDLE);
      check("mid_C", bus.C, 0);
      check("mid_qH_o", bus.qH_o, 0);
      for (int i = 0; i < 8; i++) begin
         check("mid_no_valid", bus.out_valid, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      send(60'h3, 60'h5, 43'h15, 120'hF, 1, junk_cyc);
      wait_drain(50);

      // Back-to-back spacing with out_ready high.
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         a = LOGQ'({$urandom(), $urandom()});
         b = LOGQ'({$urandom(), $urandom()});
         q = LOGQH'({$urandom(), $urandom()});
         g = {60'b0, a} * {60'b0, b};
         send(a, b, q, g, 1, t1);
         if (k > 0) check("spacing", 192'(t1 - t_prev), 192'(SPACING));
         t_prev = t1;
      end
      wait_drain(100);

      // Random stream with 70% out_ready.
      rdy_mode = 2;
      for (int k = 0; k < 1000; k++) begin
         a = LOGQ'({$urandom(), $urandom()});
         b = LOGQ'({$urandom(), $urandom()});
         q = LOGQH'({$urandom(), $urandom()});
         g = {60'b0, a} * {60'b0, b};
         send(a, b, q, g, 1, junk_cyc);
      end
      wait_drain(2000);
      rdy_mode = 1;
      repeat (10) @(posedge clk);
      #1;
      check("queue_empty", 192'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_mul.md
# digit_mul

- Digit-serial unsigned integer multiplier placed directly upstream of the word-level Montgomery reduction stage.
- Accepts two LOGQ-bit residues and the matching LOGQH-bit modulus high part over a valid/ready handshake, and produces the full 2*LOGQ-bit product C.
- The modulus high part is carried alongside as qH_o, so the reduction stage receives C and qH on the same cycle.
- Trades throughput for area: a single LOGQ×D partial-product multiplier is reused for NDIG cycles.

## Interface
- LOGQ, 60, operand width in bits
- LOGQH, 43, width of the modulus high part carried through
- D, 16, digit width of operand B; NDIG = ceil(LOGQ/D)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- A  in  LOGQ  multiplicand, unsigned
- B  in  LOGQ  multiplier, unsigned
- qH  in  LOGQH  modulus high part, carried through unchanged
- out_valid  out  1  C/qH_o valid
- out_ready  in  1  downstream accepts result
- C  out  2*LOGQ  product A*B, exact
- qH_o  out  LOGQH  qH captured with the same operands

## Operation
- States without the option: IDLE, BUSY, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid&&in_ready, register A and qH, register B zero-extended to NDIG*D bits, clear the accumulator, set cnt=0, go to BUSY.
- BUSY, each cycle: acc <= acc + ((A*B[cnt*D +: D]) << (cnt*D)).
  - Partial product width: LOGQ+D.
  - Accumulator width: exactly 2*LOGQ; no overflow is possible.
  - cnt increments each BUSY cycle.
  - When cnt==NDIG-1: write the final sum to C, copy the captured qH to qH_o, set out_valid=1, go to DONE.
- DONE: C, qH_o and out_valid held stable. On out_ready: out_valid=0, go to IDLE.
- A partial last digit (LOGQ not a multiple of D) uses zero upper bits.
- Operands of 0 are processed normally; there is no early termination.
- in_valid while not ready is ignored. A, B and qH need not stay stable after the handshake cycle.
- Reset mid-operation:
  - state returns to IDLE; the in-flight result is discarded.
  - out_valid=0, C=0, qH_o=0, acc=0, cnt=0.

## Timing
- Reset values: out_valid=0, C=0, qH_o=0. in_ready=1 in the cycle following the reset edge.
- Latency: operands accepted at edge t give out_valid=1 after edge t+NDIG.
- Throughput without the option, with out_ready held high: one result per NDIG+2 cycles.
- C and qH_o change only on the edge that sets out_valid.

## Configuration
- DIGIT_MUL_OBUF_EN defined:
  - Adds an output register decoupled from the core; states become IDLE, BUSY, STALL.
  - Final digit with the output register empty, or being drained (out_valid&&out_ready) that same cycle: load the output and go to IDLE.
  - Otherwise go to STALL, holding acc, until the output register frees; then load it and go to IDLE.
  - in_ready = (state==IDLE), so a new operation can run while the previous result awaits out_ready.
  - Throughput with out_ready high: one result per NDIG+1 cycles.
- DIGIT_MUL_OBUF_EN undefined: behaviour as in Operation.
- Latency is identical with and without the option.

## Structure
- Package digit_mul_pkg holds:
  - the state enum (IDLE, BUSY, DONE, STALL)
  - function dmul_ndig(LOGQ, D)
  - function dmul_lat(LOGQ, D), returning NDIG
- dmul_lat exists so the wrapper feeding the reduction stage can align side-band delay lines.
- Sub-module dmul_obuf: the output register with its valid/ready logic, instantiated only under DIGIT_MUL_OBUF_EN.

## Test plan
All scenarios use LOGQ=60, D=16, so NDIG=4.
- Reset: rst=0 for 2 cycles with in_valid=1 → out_valid=0, C=0, qH_o=0, in_ready=1 after release.
- Maximum operands: A=B=2^60-1, qH=0x5A5A5A5A5A5 → out_valid exactly 4 cycles after accept, C=2^120-2^61+1, qH_o=0x5A5A5A5A5A5.
- Zero and digit boundary:
  - A=0x123456789, B=0 → C=0 after 4 cycles.
  - A=1, B=0x0FFFF0000 → C=0x0FFFF0000.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - C and qH_o stable throughout.
  - Without the option: in_ready=0.
  - With DIGIT_MUL_OBUF_EN: a second operation is accepted, and the block enters STALL until the first result drains.
- Mid-operation reset: rst=0 at cnt=2 → out_valid never rises for that operation; the next operation A=3, B=5 gives C=15.
- Stream: 1000 random operations with out_ready random 70%, checked against a golden model for C and qH_o.
  - Order preserved, no drops or duplicates.
  - With out_ready=1: spacing of 6 cycles without the option, 5 with it.
